// File: rtl/instr_pair_queue_pkg.sv
// Shared constants and the stored entry layout for the fetch-to-decode pair queue.
package instr_pair_queue_pkg;

  localparam int          IPQ_DEPTH     = 4;
  localparam logic [31:0] IPQ_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] instr;
  } ipq_entry_t;

endpackage

// File: rtl/instr_pair_queue_if.sv
// Fetch-side push port and decode-side head/pop port of the pair queue.
interface instr_pair_queue_if
  import instr_pair_queue_pkg::*;
#(
  parameter int DEPTH = IPQ_DEPTH
);
  // Push fires on in_valid && in_ready at a rising edge; in_ready comes from registered
  // state only. Decode consumes pop_num instructions (capped at out_num) from the head.
  logic                     in_valid;
  logic [31:0]              in_pc;
  logic [63:0]              in_instr;
  logic                     in_ready;
  logic                     out_valid;
  logic [31:0]              out_pc;
  logic [63:0]              out_instr;
  logic [1:0]               out_num;
  logic [1:0]               pop_num;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output in_valid, in_pc, in_instr, pop_num,
    input  in_ready, out_valid, out_pc, out_instr, out_num, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, pop_num,
    output in_ready, out_valid, out_pc, out_instr, out_num, count
  );
endinterface

// File: rtl/instr_pair_queue_storage.sv
// Pair storage array: one synchronous write port, one combinational read port, no data reset.
module ipq_storage
  import instr_pair_queue_pkg::*;
#(
  parameter int DEPTH = IPQ_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  ipq_entry_t    wdata,
  input  logic [AW-1:0] raddr,
  output ipq_entry_t    rdata
);

  ipq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_pair_queue.sv
// Dual-issue decoupling FIFO: holds {pc, instr pair} entries and lets decode retire the
// head one or two instructions at a time; a taken branch flushes everything.
module instr_pair_queue
  import instr_pair_queue_pkg::*;
#(
  parameter int          DEPTH     = IPQ_DEPTH,
  parameter logic [31:0] NOP_INSTR = IPQ_NOP_INSTR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  instr_pair_queue_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          half_q,   half_d;

  ipq_entry_t head;
  logic       empty;
  logic       push;
  logic       retire;
  logic [1:0] pop_req;
  logic [1:0] pop_eff;
  logic       out_valid;
  logic [1:0] out_num;
  logic [31:0] out_pc;
  logic [63:0] out_instr;

  ipq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk   (clk),
    .we    (push && !flush),
    .waddr (wr_ptr_q),
    .wdata ({bus.in_pc, bus.in_instr}),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  assign empty       = (count_q == '0);
  assign bus.in_ready = (count_q < CW'(DEPTH));
  assign push        = bus.in_valid && bus.in_ready;

  // Head view: a half-consumed entry shifts slot 2 into the slot-1 position.
  always_comb begin
    out_valid = 1'b0;
    out_num   = 2'd0;
    out_pc    = 32'h0;
    out_instr = {NOP_INSTR, NOP_INSTR};
    if (!empty) begin
      out_valid = 1'b1;
      if (half_q) begin
        out_num   = 2'd1;
        out_pc    = head.pc + 32'd4;
        out_instr = {head.instr[31:0], NOP_INSTR};
      end else begin
        out_num   = 2'd2;
        out_pc    = head.pc;
        out_instr = head.instr;
      end
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_num   = out_num;
  assign bus.out_pc    = out_pc;
  assign bus.out_instr = out_instr;
  assign bus.count     = count_q;

  always_comb begin
    pop_req  = (bus.pop_num == 2'd3) ? 2'd2 : bus.pop_num;
    pop_eff  = (pop_req > out_num) ? out_num : pop_req;
    retire   = (pop_eff == 2'd2) || ((pop_eff == 2'd1) && half_q);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    half_d   = half_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      half_d   = 1'b0;
    end else begin
      if (push)   wr_ptr_d = wr_ptr_q + AW'(1);
      if (retire) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        half_d   = 1'b0;
      end else if (pop_eff == 2'd1) begin
        half_d   = 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(retire);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      half_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      half_q   <= half_d;
    end
  end

endmodule

// File: tb/tb_instr_pair_queue.sv
// Bench for instr_pair_queue: directed pushes/pops feed a queue model; a negedge monitor
// compares every presented head and status flag against it.
module tb_instr_pair_queue;
  import instr_pair_queue_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk;
  logic rst;
  logic flush;

  instr_pair_queue_if #(.DEPTH(DEPTH)) bus ();

  instr_pair_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [95:0] exp_q[$];
  logic        m_half = 1'b0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: applies issue-side effects at each edge
  always @(posedge clk or negedge rst) begin
    int         sz;
    logic [1:0] mnum, preq, e;
    if (!rst) begin
      exp_q.delete();
      m_half = 1'b0;
    end else if (flush) begin
      exp_q.delete();
      m_half = 1'b0;
    end else begin
      sz   = exp_q.size();
      mnum = (sz == 0) ? 2'd0 : (m_half ? 2'd1 : 2'd2);
      preq = (bus.pop_num == 2'd3) ? 2'd2 : bus.pop_num;
      e    = (preq > mnum) ? mnum : preq;
      if (e == 2'd2 || (e == 2'd1 && m_half)) begin
        void'(exp_q.pop_front());
        m_half = 1'b0;
      end else if (e == 2'd1) begin
        m_half = 1'b1;
      end
      if (bus.in_valid && sz < DEPTH) exp_q.push_back({bus.in_pc, bus.in_instr});
    end
  end

  // monitor
  always @(negedge clk) begin
    logic [95:0] h;
    int          sz;
    sz = exp_q.size();
    check("count",     64'(bus.count),     64'(sz));
    check("in_ready",  64'(bus.in_ready),  64'(sz < DEPTH));
    check("out_valid", 64'(bus.out_valid), 64'(sz != 0));
    if (sz != 0) begin
      h = exp_q[0];
      if (m_half) begin
        check("head_num",   64'(bus.out_num), 64'd1);
        check("head_pc",    64'(bus.out_pc),  64'(h[95:64] + 32'd4));
        check("head_instr", bus.out_instr,    {h[31:0], NOP});
      end else begin
        check("head_num",   64'(bus.out_num), 64'd2);
        check("head_pc",    64'(bus.out_pc),  64'(h[95:64]));
        check("head_instr", bus.out_instr,    h[63:0]);
      end
    end else begin
      check("empty_num",   64'(bus.out_num), 64'd0);
      check("empty_pc",    64'(bus.out_pc),  64'd0);
      check("empty_instr", bus.out_instr,    {NOP, NOP});
    end
  end

  // driver tasks
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [63:0] ins,
                     input logic [1:0] pop, input logic fl);
    bus.in_valid = v;
    bus.in_pc    = pc;
    bus.in_instr = ins;
    bus.pop_num  = pop;
    flush        = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [31:0] pc);
    cyc(1'b1, pc, {pc, ~pc}, 2'd0, 1'b0);
  endtask

  task automatic idle_pop(input logic [1:0] pop);
    cyc(1'b0, 32'h0, 64'h0, pop, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_pc = '0;
    bus.in_instr = '0;
    bus.pop_num = '0;
    #1;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_instr", bus.out_instr, {NOP, NOP});
    check("rst_ready", 64'(bus.in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // pop on empty is ignored
    idle_pop(2'd2);
    check("empty_pop_count", 64'(bus.count), 64'd0);

    // basic fill / drain
    for (int i = 0; i < 4; i++) push_pair(32'(i * 8));
    check("fill_count", 64'(bus.count), 64'd4);
    check("fill_ready", 64'(bus.in_ready), 64'd0);
    check("fill_head", 64'(bus.out_pc), 64'h0);
    for (int i = 0; i < 4; i++) idle_pop(2'd2);
    check("drain_count", 64'(bus.count), 64'd0);
    check("drain_valid", 64'(bus.out_valid), 64'd0);

    // partial issue
    cyc(1'b1, 32'h40, 64'hAAAA0001_BBBB0002, 2'd0, 1'b0);
    idle_pop(2'd1);
    check("part_instr", bus.out_instr, 64'hBBBB0002_00000013);
    check("part_pc", 64'(bus.out_pc), 64'h44);
    check("part_num", 64'(bus.out_num), 64'd1);
    check("part_count", 64'(bus.count), 64'd1);
    idle_pop(2'd2);
    check("part_retire", 64'(bus.count), 64'd0);

    // flush priority over push and pop
    for (int i = 0; i < 3; i++) push_pair(32'h100 + 32'(i * 8));
    cyc(1'b1, 32'h200, 64'h1234, 2'd2, 1'b1);
    check("flush_count", 64'(bus.count), 64'd0);
    check("flush_valid", 64'(bus.out_valid), 64'd0);
    check("flush_ready", 64'(bus.in_ready), 64'd1);
    idle_pop(2'd0);
    check("flush_absent", 64'(bus.out_valid), 64'd0);

    // steady push+pop across pointer wrap
    push_pair(32'h300);
    push_pair(32'h308);
    for (int i = 0; i < 10; i++) begin
      check("wrap_pc", 64'(bus.out_pc), 64'(32'h300 + 32'(i * 8)));
      cyc(1'b1, 32'h310 + 32'(i * 8), {32'h310 + 32'(i * 8), ~(32'h310 + 32'(i * 8))},
          (i % 2 == 0) ? 2'd2 : 2'd3, 1'b0);
      check("wrap_count", 64'(bus.count), 64'd2);
    end
    idle_pop(2'd3);
    idle_pop(2'd2);
    check("wrap_drain", 64'(bus.count), 64'd0);

    // full boundary: in_ready stays low even with a pop this cycle
    for (int i = 0; i < 4; i++) push_pair(32'h600 + 32'(i * 8));
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h700;
    bus.in_instr = 64'h0700;
    bus.pop_num  = 2'd2;
    check("full_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    check("full_count", 64'(bus.count), 64'd3);
    check("full_ready_next", 64'(bus.in_ready), 64'd1);
    check("full_head", 64'(bus.out_pc), 64'h608);
    for (int i = 0; i < 3; i++) idle_pop(2'd2);

    // asynchronous reset mid-cycle with a half-consumed head
    push_pair(32'h500);
    push_pair(32'h508);
    idle_pop(2'd1);
    check("pre_rst_count", 64'(bus.count), 64'd2);
    check("pre_rst_pc", 64'(bus.out_pc), 64'h504);
    bus.pop_num = 2'd0;
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 64'(bus.out_valid), 64'd0);
    check("arst_num", 64'(bus.out_num), 64'd0);
    check("arst_pc", 64'(bus.out_pc), 64'd0);
    check("arst_instr", bus.out_instr, {NOP, NOP});
    check("arst_count", 64'(bus.count), 64'd0);
    check("arst_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    idle_pop(2'd0);
    check("post_rst_valid", 64'(bus.out_valid), 64'd0);
    check("post_rst_count", 64'(bus.count), 64'd0);

    idle_pop(2'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_pair_queue.md
Name: instr_pair_queue

Overview:
- Decoupling FIFO between the dual-issue fetch stage and the two decode slots.
- Buffers 64-bit instruction pairs with their PC. Slot 1 is bits [63:32] at pc; slot 2 is bits [31:0] at pc+4.
- Presents the head pair to decode1/decode2.
- Supports partial issue: the flow-control unit may consume only slot 1 when slot 2 stalls.
- Flushed on a taken branch from exec.

Parameters:
- DEPTH, 4, number of pair entries; power of two, minimum 2.
- NOP_INSTR, 32'h00000013, instruction (addi x0,x0,0) driven into unused or empty slots.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  asynchronous active-low reset.
- flush  in  1  taken branch (ex_br_taken); clears the queue.
- in_valid  in  1  fetch presents a pair.
- in_pc  in  32  PC of slot 1 of the incoming pair.
- in_instr  in  64  incoming pair; [63:32] = slot 1, [31:0] = slot 2.
- in_ready  out  1  queue accepts a pair this cycle.
- out_valid  out  1  head holds at least one unissued instruction.
- out_pc  out  32  PC of the instruction in out_instr[63:32].
- out_instr  out  64  head pair to decode1 ([63:32]) and decode2 ([31:0]).
- out_num  out  2  valid instructions in out_instr: 0, 1 or 2.
- pop_num  in  2  instructions decode consumes this cycle: 0, 1 or 2.
- count  out  $clog2(DEPTH)+1  occupied entries, including a half-consumed head.

Behaviour:
- Reset (rst=0, asynchronous), applied immediately and held until release:
  - write pointer, read pointer, count and half flag = 0.
  - in_ready=1, out_valid=0, out_num=0, out_pc=0, out_instr={NOP_INSTR,NOP_INSTR}.
- Storage: DEPTH entries of {pc[31:0], instr[63:0]}; circular pointers wrap modulo DEPTH.
- Push:
  - Occurs when in_valid && in_ready.
  - in_ready = (count < DEPTH). It depends only on registered state; there is no combinational path from pop_num.
  - When full, in_ready=0 even if a pop occurs this cycle.
- Latency and read side:
  - A pushed pair is visible on the outputs the cycle after the push edge. There is no bypass.
  - Outputs are a combinational read of the head entry.
- Head presentation:
  - Empty: out_valid=0, out_num=0, out_instr={NOP,NOP}, out_pc=0.
  - Non-empty, half=0: out_instr=entry.instr, out_pc=entry.pc, out_num=2.
  - Non-empty, half=1: out_instr={entry.instr[31:0], NOP_INSTR}, out_pc=entry.pc+4, out_num=1.
- Pop: effective pop e = min(pop_num, out_num); pop_num=3 is treated as 2.
  - e=0: no change.
  - e=1 with half=0: set half=1; the entry is retained.
  - e=1 with half=1: retire the entry and clear half.
  - e=2: retire the entry; half stays 0.
  - Pop when empty is ignored.
- Count:
  - count_next = count + push - retire.
  - Simultaneous push and retire keeps count unchanged; both pointers advance.
- Flush (synchronous, highest priority):
  - Pointers, count and half are cleared.
  - A push and a pop in the same cycle are both discarded.
  - Next cycle: out_valid=0, in_ready=1.
- Reset mid-operation: all contents are abandoned; no partial state survives.
- Pointer wrap: the entry after index DEPTH-1 is index 0; order is preserved across wrap.
- Arithmetic:
  - out_pc+4 is 32-bit modulo.
  - count uses one extra bit so the full condition is distinct from empty.

Decomposition:
- Shared package/define file holds NOP_INSTR and the DEPTH default, next to the existing define constants.
- Sub-module ipq_storage: DEPTH x 96-bit register array with one write port and one combinational read port, no reset on data.
- Pointers, count, half flag and output muxing stay in instr_pair_queue.

Test Plan:
- Basic fill/drain:
  - Stimulus: push 4 pairs, pc=0x00,0x08,0x10,0x18, instr={pc,~pc}.
  - Response: count=4, in_ready=0. Pop 2 each cycle; pairs emerge in order, out_num=2; after the last pop, count=0 and out_valid=0.
- Partial issue:
  - Stimulus: head pc=0x40, instr={0xAAAA0001,0xBBBB0002}; apply pop_num=1.
  - Response: next cycle out_instr={0xBBBB0002,0x00000013}, out_pc=0x44, out_num=1, count unchanged. Apply pop_num=2; entry retires, count decrements by 1.
- Flush priority:
  - Stimulus: 3 entries queued; assert flush together with in_valid=1 and pop_num=2.
  - Response: next cycle count=0, out_valid=0, in_ready=1; the pushed pair is absent.
- Simultaneous push/pop and wrap:
  - Stimulus: keep count=2 while pushing and popping 2 every cycle for 10 cycles.
  - Response: count stays 2, pointers wrap, PCs exit strictly ascending by 8.
- Full boundary:
  - Stimulus: count=4 with in_valid=1 and pop_num=2.
  - Response: in_ready=0, push rejected; next cycle count=3, in_ready=1.
- Async reset:
  - Stimulus: drop rst mid-cycle with 2 entries held and half=1.
  - Response: outputs go to reset values immediately; after release, out_valid=0 and count=0.
